reg_read_scoreboard: RTL and testbench
======================================

Name: reg_read_scoreboard

Overview:
- Register-file read side and write-back consumer for the destination register number chosen at decode.
- Holds the 32x32 general register file, with one write port (WB stage) and two read ports (ID stage).
- Tracks in-flight writes per register with a counter scoreboard, so decode stalls on a read-after-write (RAW) hazard.
- Sits between the decode-stage destination-select logic and the ID/EX pipeline register.

Parameters:
- DATA_W, 32, register width.
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writes per register = 2^CNT_W - 1.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  the ID-stage instruction is valid and wants to advance.
- issue_we  in  1  the issuing instruction writes a register.
- issue_rw  in  5  destination register number from the decode-stage destination select.
- rs_id  in  5  source register A number.
- rt_id  in  5  source register B number.
- rs_used  in  1  source A is actually read.
- rt_used  in  1  source B is actually read.
- wb_we  in  1  write-back enable.
- wb_rw  in  5  write-back register number.
- wb_data  in  DATA_W  write-back data.
- rs_data  out  DATA_W  register A value.
- rt_data  out  DATA_W  register B value.
- stall_id  out  1  hold the ID stage; the instruction is not issued.
- issue_fire  out  1  equals issue_valid & ~stall_id.

Behaviour:
- Reset (rst=1 at a clock edge): all 32 registers := 0; all pending counters := 0. Outputs settle combinationally to rs_data=rt_data=0, stall_id=0, issue_fire=0 when issue_valid=0. Reset asserted mid-operation discards all pending state immediately.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Its pending counter never changes.
  - Sources equal to 0 never stall.
- Write: on a clock edge with wb_we=1 and wb_rw!=0, reg[wb_rw] := wb_data.
- Read: rs_data and rt_data are combinational (zero latency). When wb_we=1 and wb_rw equals the source number (nonzero), the output is wb_data (write-through bypass).
- Counters: pend[r] counts issued-but-not-written-back writes to register r.
  - Increment when issue_fire & issue_we & issue_rw!=0.
  - Decrement when wb_we & wb_rw!=0.
  - Same-cycle increment and decrement of the same register: count unchanged.
  - A decrement at count 0 is a protocol error. The count stays 0 (no wrap).
- Effective pending for the hazard check: eff(r) = pend[r] - (wb_we & wb_rw==r ? 1 : 0).
- stall_id = issue_valid & ( (rs_used & rs_id!=0 & eff(rs_id)!=0) | (rt_used & rt_id!=0 & eff(rt_id)!=0) | (issue_we & issue_rw!=0 & pend[issue_rw]==2^CNT_W-1 & ~(wb_we & wb_rw==issue_rw)) ).
- The last term is the overflow guard: the counter saturates at 3, and a fourth issue to the same register stalls.
- No stall when issue_valid=0. Stalling never alters counters or registers.
- The pipeline guarantees in-order write-back. Flushed instructions with issue_we=1 must still deliver a write-back (data may be discarded upstream) so that counters drain.

Optional Feature:
- Macro: REG_READ_BYPASS_EN.
- Defined: same-cycle write-through bypass as described above; eff() subtracts the retiring write.
- Undefined:
  - rs_data and rt_data always come from storage.
  - eff(r)=pend[r], so a source whose write-back is in the current cycle stalls one extra cycle.
  - The overflow guard ignores a same-cycle write-back.

Test Plan:
- Reset, then read rs_id=5, rt_id=0 -> rs_data=0, rt_data=0, stall_id=0; write wb_rw=0, wb_data=0xDEADBEEF, then read r0 -> 0.
- Write r3=0x12345678 with no pending; next cycle rs_id=3 -> rs_data=0x12345678, stall_id=0.
- Issue a write to r7 (pend=1), next cycle read r7 with rs_used=1 -> stall_id=1 until wb_we with wb_rw=7, wb_data=0xA5A5A5A5. With BYPASS_EN, stall_id=0 in that write-back cycle and rs_data=0xA5A5A5A5; without it, the stall holds one more cycle.
- Three issues to r9 without write-back -> pend=3; the fourth issue to r9 -> stall_id=1, counter stays 3; a write-back to r9 in the same cycle (BYPASS_EN) -> issue_fire=1, counter stays 3.
- Issue to r4 and write-back r4 in the same cycle with pend[4]=1 -> pend stays 1; reset mid-flight with pend[4]=2 -> pend=0 and r4=0 next cycle; read r4 -> no stall.
- rs_used=0 with rs_id pending -> stall_id=0; issue_valid=0 with hazard present -> stall_id=0, issue_fire=0.

Source files
------------

// File: rtl/reg_read_scoreboard.sv
// 32-entry register file with two combinational read ports, one write-back port and a per-register pending-write scoreboard.
// Optional macro REG_READ_BYPASS_EN enables same-cycle write-through and retire-aware hazard checks.
module reg_read_scoreboard #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [4:0]        issue_rw,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              wb_we,
  input  logic [4:0]        wb_rw,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall_id,
  output logic              issue_fire
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0][DATA_W-1:0] regs_rd;
  logic [31:0][CNT_W-1:0]  pend;
  logic                    wb_active;
  logic                    issue_inc;
  logic                    rs_hazard;
  logic                    rt_hazard;
  logic                    full_hazard;

  assign wb_active = wb_we & (wb_rw != 5'd0);
  assign issue_inc = issue_fire & issue_we & (issue_rw != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_rd[gi] = '0;
        assign pend[gi]    = '0;
      end else begin : g_live
        logic [DATA_W-1:0] word_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              hit_wb;
        logic              hit_issue;

        assign hit_wb    = wb_active & (wb_rw == 5'(gi));
        assign hit_issue = issue_inc & (issue_rw == 5'(gi));

        // A decrement at zero is a protocol error; hold at zero instead of wrapping.
        always_comb begin
          cnt_d = cnt_q;
          if (hit_issue && !hit_wb) begin
            cnt_d = cnt_q + 1'b1;
          end else if (hit_wb && !hit_issue && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (hit_wb) begin
              word_q <= wb_data;
            end
          end
        end

        assign regs_rd[gi] = word_q;
        assign pend[gi]    = cnt_q;
      end
    end
  endgenerate

`ifdef REG_READ_BYPASS_EN
  logic rs_retire;
  logic rt_retire;
  logic rw_retire;

  assign rs_retire = wb_active & (wb_rw == rs_id);
  assign rt_retire = wb_active & (wb_rw == rt_id);
  assign rw_retire = wb_active & (wb_rw == issue_rw);

  assign rs_data = rs_retire ? wb_data : regs_rd[rs_id];
  assign rt_data = rt_retire ? wb_data : regs_rd[rt_id];

  // The retiring write no longer counts as pending, so only the last one clears the hazard.
  assign rs_hazard = rs_used & (rs_id != 5'd0) & (pend[rs_id] != '0)
                   & ~(rs_retire & (pend[rs_id] == CNT_W'(1)));
  assign rt_hazard = rt_used & (rt_id != 5'd0) & (pend[rt_id] != '0)
                   & ~(rt_retire & (pend[rt_id] == CNT_W'(1)));
  assign full_hazard = issue_we & (issue_rw != 5'd0) & (pend[issue_rw] == CNT_MAX) & ~rw_retire;
`else
  assign rs_data = regs_rd[rs_id];
  assign rt_data = regs_rd[rt_id];

  assign rs_hazard   = rs_used & (rs_id != 5'd0) & (pend[rs_id] != '0);
  assign rt_hazard   = rt_used & (rt_id != 5'd0) & (pend[rt_id] != '0);
  assign full_hazard = issue_we & (issue_rw != 5'd0) & (pend[issue_rw] == CNT_MAX);
`endif

  assign stall_id   = issue_valid & (rs_hazard | rt_hazard | full_hazard);
  assign issue_fire = issue_valid & ~stall_id;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Bench for reg_read_scoreboard: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based model of in-flight writes.
module tb_reg_read_scoreboard;

`ifdef REG_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rw;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        rs_used;
  logic        rt_used;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall_id;
  logic        issue_fire;

  reg_read_scoreboard #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rw(issue_rw),
    .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data),
    .rs_data(rs_data), .rt_data(rt_data), .stall_id(stall_id), .issue_fire(issue_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        iwe;
    logic [4:0]  irw;
    logic [4:0]  rs;
    logic        rsu;
    logic [4:0]  rt;
    logic        rtu;
    logic        wbwe;
    logic [4:0]  wbrw;
    logic [31:0] wbd;
    logic [31:0] ers;
    logic [31:0] ert;
    logic        estall;
    logic        efire;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: architectural register values and the ordered list of in-flight destinations.
  logic [31:0] m_regs [32];
  int          m_q[$];

  function automatic vec_t mk(input int r, input int iv, input int iwe, input int irw,
                              input int rs, input int rsu, input int rt, input int rtu,
                              input int wbwe, input int wbrw, input logic [31:0] wbd,
                              input logic [31:0] ers, input logic [31:0] ert,
                              input int est, input int efi);
    vec_t v;
    v.rst = (r != 0);     v.iv = (iv != 0);     v.iwe = (iwe != 0);
    v.irw = 5'(irw);      v.rs = 5'(rs);        v.rsu = (rsu != 0);
    v.rt = 5'(rt);        v.rtu = (rtu != 0);   v.wbwe = (wbwe != 0);
    v.wbrw = 5'(wbrw);    v.wbd = wbd;          v.ers = ers;
    v.ert = ert;          v.estall = (est != 0); v.efire = (efi != 0);
    return v;
  endfunction

  function automatic int m_pend(input int r);
    int c = 0;
    foreach (m_q[k]) if (m_q[k] == r) c++;
    return c;
  endfunction

  function automatic int m_eff(input int r);
    int p = m_pend(r);
    if (BYP && wb_we && (int'(wb_rw) == r) && (r != 0) && (p > 0)) p = p - 1;
    return p;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit use_model, input int idx);
    logic [31:0] e_rs, e_rt;
    logic        e_stall, e_fire;
    rst = v.rst; issue_valid = v.iv; issue_we = v.iwe; issue_rw = v.irw;
    rs_id = v.rs; rs_used = v.rsu; rt_id = v.rt; rt_used = v.rtu;
    wb_we = v.wbwe; wb_rw = v.wbrw; wb_data = v.wbd;
    @(negedge clk);
    if (use_model) begin
      e_rs = (rs_id == 0) ? 32'h0 : (BYP && wb_we && wb_rw == rs_id) ? wb_data : m_regs[rs_id];
      e_rt = (rt_id == 0) ? 32'h0 : (BYP && wb_we && wb_rw == rt_id) ? wb_data : m_regs[rt_id];
      e_stall = issue_valid && (
                  (rs_used && rs_id != 0 && m_eff(int'(rs_id)) != 0) ||
                  (rt_used && rt_id != 0 && m_eff(int'(rt_id)) != 0) ||
                  (issue_we && issue_rw != 0 && m_pend(int'(issue_rw)) == 3 &&
                   !(BYP && wb_we && wb_rw == issue_rw)));
      e_fire = issue_valid && !e_stall;
    end else begin
      e_rs = v.ers; e_rt = v.ert; e_stall = v.estall; e_fire = v.efire;
    end
    check("rs_data", idx, rs_data, e_rs);
    check("rt_data", idx, rt_data, e_rt);
    check("stall_id", idx, {31'h0, stall_id}, {31'h0, e_stall});
    check("issue_fire", idx, {31'h0, issue_fire}, {31'h0, e_fire});
    $display("cycle %0d: rst=%0b iv=%0b we=%0b rw=%0d rs=%0d rt=%0d wb=%0b/%0d -> rs=%h rt=%h stall=%0b fire=%0b",
             idx, rst, issue_valid, issue_we, issue_rw, rs_id, rt_id, wb_we, wb_rw,
             rs_data, rt_data, stall_id, issue_fire);
    @(posedge clk);
    if (use_model) begin
      if (rst) begin
        foreach (m_regs[k]) m_regs[k] = 32'h0;
        m_q.delete();
      end else begin
        if (wb_we && wb_rw != 0) begin
          m_regs[wb_rw] = wb_data;
          if (m_q.size() > 0) void'(m_q.pop_front());
        end
        if (e_fire && issue_we && issue_rw != 0) m_q.push_back(int'(issue_rw));
      end
    end
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   nxt;

    foreach (m_regs[k]) m_regs[k] = 32'h0;

    // Directed table from a freshly reset state.
    tbl.push_back(mk(0,0,0,0, 5,1,0,1, 0,0,32'h0,        32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,0,1, 1,0,32'hDEADBEEF, 32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,1,0,1, 0,0,32'h0,        32'h0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,3,32'h12345678, 32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 3,1,0,0, 0,0,32'h0,        32'h12345678,0,0,1));
    tbl.push_back(mk(0,1,1,7, 3,1,3,1, 0,0,32'h0,        32'h12345678,32'h12345678,0,1));
    tbl.push_back(mk(0,1,0,0, 7,1,0,0, 0,0,32'h0,        32'h0,0,1,0));
    tbl.push_back(mk(0,1,0,0, 0,0,7,1, 0,0,32'h0,        32'h0,0,1,0));
    tbl.push_back(mk(0,1,0,0, 7,0,7,0, 0,0,32'h0,        32'h0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 7,1,7,1, 0,0,32'h0,        32'h0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 7,1,0,0, 1,7,32'hA5A5A5A5,
                     BYP ? 32'hA5A5A5A5 : 32'h0, 0, BYP ? 0 : 1, BYP ? 1 : 0));
    tbl.push_back(mk(0,1,0,0, 7,1,0,0, 0,0,32'h0,        32'hA5A5A5A5,0,0,1));

    rst = 1'b1; issue_valid = 0; issue_we = 0; issue_rw = 0; rs_id = 0; rt_id = 0;
    rs_used = 0; rt_used = 0; wb_we = 0; wb_rw = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], 1'b0, i);
    nxt = tbl.size();

    // r9 overflow guard, then drain the counter to show it held at 3.
    repeat (3) begin apply(mk(0,1,1,9, 0,0,0,0, 0,0,32'h0, 32'h0,0,0,1), 1'b0, nxt); nxt++; end
    repeat (2) begin apply(mk(0,1,1,9, 0,0,0,0, 0,0,32'h0, 32'h0,0,1,0), 1'b0, nxt); nxt++; end
    apply(mk(0,1,1,9, 0,0,0,0, 1,9,32'h99, 32'h0,0, BYP ? 0 : 1, BYP ? 1 : 0), 1'b0, nxt++);
    apply(mk(0,1,0,0, 9,1,0,0, 0,0,32'h0,  32'h99,0,1,0), 1'b0, nxt++);
    apply(mk(0,1,0,0, 9,1,0,0, 1,9,32'h91, BYP ? 32'h91 : 32'h99, 0,1,0), 1'b0, nxt++);
    apply(mk(0,1,0,0, 9,1,0,0, 1,9,32'h92, BYP ? 32'h92 : 32'h91, 0,1,0), 1'b0, nxt++);
    apply(mk(0,1,0,0, 9,1,0,0, 0,0,32'h0,  32'h92,0, BYP ? 1 : 0, BYP ? 0 : 1), 1'b0, nxt++);
    apply(mk(0,1,0,0, 9,1,0,0, 1,9,32'h93, BYP ? 32'h93 : 32'h92, 0,0,1), 1'b0, nxt++);

    // r4: same-cycle issue and write-back, then reset with two writes in flight.
    apply(mk(0,1,1,4, 0,0,0,0, 0,0,32'h0,  32'h0,0,0,1), 1'b0, nxt++);
    apply(mk(0,1,1,4, 0,0,4,0, 1,4,32'h44, 32'h0, BYP ? 32'h44 : 32'h0, 0,1), 1'b0, nxt++);
    apply(mk(0,1,1,4, 4,0,0,0, 0,0,32'h0,  32'h44,0,0,1), 1'b0, nxt++);
    apply(mk(0,0,0,0, 0,0,0,0, 1,4,32'h45, 32'h0,0,0,0), 1'b0, nxt++);
    apply(mk(0,1,0,0, 4,1,0,0, 0,0,32'h0,  32'h45,0,1,0), 1'b0, nxt++);
    apply(mk(0,1,1,4, 0,0,0,0, 0,0,32'h0,  32'h0,0,0,1), 1'b0, nxt++);
    apply(mk(1,0,0,0, 4,1,0,0, 0,0,32'h0,  32'h45,0,0,0), 1'b0, nxt++);
    apply(mk(0,1,0,0, 4,1,0,0, 0,0,32'h0,  32'h0,0,0,1), 1'b0, nxt++);

    // Random traffic; write-backs retire the oldest in-flight destination in order.
    for (int i = 0; i < 400; i++) begin
      int wbwe, wbrw;
      if (m_q.size() > 0 && ($urandom % 2) == 0) begin
        wbwe = 1; wbrw = m_q[0];
      end else if (($urandom % 8) == 0) begin
        wbwe = 1; wbrw = 0;
      end else begin
        wbwe = 0; wbrw = int'($urandom_range(0, 31));
      end
      v = mk(($urandom % 100) == 0 ? 1 : 0, ($urandom % 4) != 0 ? 1 : 0,
             ($urandom % 3) != 0 ? 1 : 0, int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             wbwe, wbrw, $urandom, 32'h0, 32'h0, 0, 0);
      apply(v, 1'b1, nxt++);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
